// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: RV32M issue front end for a sequential Booth radix-4 multiplier core,
// with signedness extension, a one-entry product cache and flush/drain handling.
module mul_issue_ctrl #(
   parameter int XLEN     = 32,
   parameter bit CACHE_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_rs1,
   input  logic [XLEN-1:0]   req_rs2,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_result,
   output logic              resp_err,
   output logic              core_start,
   output logic [XLEN:0]     core_a,
   output logic [XLEN:0]     core_b,
   input  logic [2*XLEN+1:0] core_product,
   input  logic              core_done,
   output logic              busy
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_RESP   = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;
   logic [2:0]        state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [XLEN:0]     a_q, a_d, b_q, b_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              err_q, err_d;
   logic              cache_valid_q, cache_valid_d;
   logic [XLEN:0]     cache_a_q, cache_a_d, cache_b_q, cache_b_d;
   logic [2*XLEN-1:0] cache_p_q, cache_p_d;
   logic              accept, illegal, hit;
   logic [XLEN:0]     ext_a, ext_b;
   logic [XLEN-1:0]   cache_sel, core_sel;
   logic              unused_product_top;
   assign req_ready   = (state_q == S_IDLE) && !flush;
   assign accept      = req_valid && req_ready;
   assign illegal     = req_funct3[2];
   // rs1 is signed unless MULHU; rs2 is signed only for MUL/MULH
   assign ext_a       = {~(req_funct3[1] & req_funct3[0]) & req_rs1[XLEN-1], req_rs1};
   assign ext_b       = {~req_funct3[1] & req_rs2[XLEN-1], req_rs2};
   assign hit         = CACHE_EN && cache_valid_q && (ext_a == cache_a_q) && (ext_b == cache_b_q);
   assign cache_sel   = (req_funct3[1:0] == 2'b00) ? cache_p_q[XLEN-1:0] : cache_p_q[2*XLEN-1:XLEN];
   assign core_sel    = (funct3_q[1:0] == 2'b00) ? core_product[XLEN-1:0] : core_product[2*XLEN-1:XLEN];
   assign unused_product_top = ^core_product[2*XLEN+1:2*XLEN];
   assign resp_valid  = state_q == S_RESP;
   assign core_start  = state_q == S_LAUNCH;
   assign busy        = state_q != S_IDLE;
   assign resp_result = result_q;
   assign resp_err    = err_q;
   assign core_a      = a_q;
   assign core_b      = b_q;
   always_comb begin
      state_d       = state_q;
      funct3_d      = funct3_q;
      a_d           = a_q;
      b_d           = b_q;
      result_d      = result_q;
      err_d         = err_q;
      cache_valid_d = cache_valid_q;
      cache_a_d     = cache_a_q;
      cache_b_d     = cache_b_q;
      cache_p_d     = cache_p_q;
      case (state_q)
         S_IDLE: if (accept) begin
            funct3_d = req_funct3;
            a_d      = ext_a;
            b_d      = ext_b;
            err_d    = illegal;
            result_d = illegal ? '0 : hit ? cache_sel : result_q;
            state_d  = (illegal || hit) ? S_RESP : S_LAUNCH;
         end
         S_LAUNCH: state_d = flush ? S_DRAIN : S_WAIT;
         S_WAIT: if (flush) begin
            state_d = core_done ? S_IDLE : S_DRAIN;
         end else if (core_done) begin
            cache_valid_d = 1'b1;
            cache_a_d     = a_q;
            cache_b_d     = b_q;
            cache_p_d     = core_product[2*XLEN-1:0];
            result_d      = core_sel;
            state_d       = S_RESP;
         end
         S_RESP:  state_d = (flush || resp_ready) ? S_IDLE : S_RESP;
         S_DRAIN: state_d = core_done ? S_IDLE : S_DRAIN;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         funct3_q      <= '0;
         a_q           <= '0;
         b_q           <= '0;
         result_q      <= '0;
         err_q         <= 1'b0;
         cache_valid_q <= 1'b0;
         cache_a_q     <= '0;
         cache_b_q     <= '0;
         cache_p_q     <= '0;
      end else begin
         state_q       <= state_d;
         funct3_q      <= funct3_d;
         a_q           <= a_d;
         b_q           <= b_d;
         result_q      <= result_d;
         err_q         <= err_d;
         cache_valid_q <= cache_valid_d;
         cache_a_q     <= cache_a_d;
         cache_b_q     <= cache_b_d;
         cache_p_q     <= cache_p_d;
      end
   end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed vectors for mul_issue_ctrl against a fixed-latency multiplier core stub.
module tb_mul_issue_ctrl;
   localparam int CORE_LAT = 4;
   typedef struct {
      logic [2:0]  f;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] res;
      logic        err;
      int          starts;
      logic [32:0] a;
      logic [32:0] b;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst, flush, req_valid, req_ready, resp_valid, resp_ready, resp_err;
   logic        core_start, core_done, busy;
   logic [2:0]  req_funct3;
   logic [31:0] req_rs1, req_rs2, resp_result;
   logic [32:0] core_a, core_b, m_a, m_b, a_seen, b_seen;
   logic [65:0] core_product;
   int          lat_cnt, start_cnt = 0;
   int          n_checks = 0, n_fail = 0;
   vec_t        vecs[18];
   mul_issue_ctrl #(.XLEN(32), .CACHE_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
      .req_rs1(req_rs1), .req_rs2(req_rs2),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result), .resp_err(resp_err),
      .core_start(core_start), .core_a(core_a), .core_b(core_b),
      .core_product(core_product), .core_done(core_done), .busy(busy)
   );
   always #5 clk = ~clk;
   // core stub: signed 33x33 multiply, done pulses CORE_LAT cycles after the start edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_cnt      <= 0;
         core_done    <= 1'b0;
         core_product <= '0;
      end else begin
         core_done <= 1'b0;
         if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
               core_done    <= 1'b1;
               core_product <= {{33{m_a[32]}}, m_a} * {{33{m_b[32]}}, m_b};
            end
         end else if (core_start) begin
            lat_cnt <= CORE_LAT;
            m_a     <= core_a;
            m_b     <= core_b;
         end
      end
   end
   always @(posedge clk) begin
      if (core_start) begin
         start_cnt <= start_cnt + 1;
         a_seen    <= core_a;
         b_seen    <= core_b;
      end
   end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask
   task automatic issue(input logic [2:0] f, input logic [31:0] rs1, input logic [31:0] rs2, input string nm);
      int cyc;
      @(negedge clk);
      req_valid  = 1'b1;
      req_funct3 = f;
      req_rs1    = rs1;
      req_rs2    = rs2;
      cyc = 0;
      while (!req_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, " req_ready"}, 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask
   task automatic wait_idle(input string nm);
      int cyc;
      logic seen;
      cyc  = 0;
      seen = 1'b0;
      while (busy && cyc < 50) begin
         seen |= resp_valid;
         @(negedge clk);
         cyc++;
      end
      chk({nm, " drain to idle"}, 64'(busy), 64'd0);
      chk({nm, " no response"}, 64'(seen), 64'd0);
   endtask
   task automatic run_op(input vec_t v, input string nm);
      int cyc, s0;
      s0 = start_cnt;
      issue(v.f, v.rs1, v.rs2, nm);
      cyc = 1;
      while (!resp_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, " resp_valid"}, 64'(resp_valid), 64'd1);
      chk({nm, " result"}, 64'(resp_result), 64'(v.res));
      chk({nm, " err"}, 64'(resp_err), 64'(v.err));
      chk({nm, " core starts"}, 64'(start_cnt - s0), 64'(v.starts));
      if (v.starts == 0) chk({nm, " latency"}, 64'(cyc), 64'd1);
      else begin
         chk({nm, " core_a"}, 64'(a_seen), 64'(v.a));
         chk({nm, " core_b"}, 64'(b_seen), 64'(v.b));
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({nm, " resp_valid after handshake"}, 64'(resp_valid), 64'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      int s0;
      vecs[0]  = '{3'b000, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFEB, 1'b0, 1, 33'h1FFFFFFF9, 33'h000000003};
      vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1, 33'h0FFFFFFFF, 33'h0FFFFFFFF};
      vecs[2]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, 33'h1FFFFFFFF, 33'h0FFFFFFFF};
      vecs[3]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1, 33'h180000000, 33'h180000000};
      vecs[4]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 0, 33'h0, 33'h0};
      vecs[5]  = '{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1, 33'h080000000, 33'h080000000};
      vecs[6]  = '{3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 1'b0, 1, 33'h07FFFFFFF, 33'h07FFFFFFF};
      vecs[7]  = '{3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 33'h0, 33'h0};
      vecs[8]  = '{3'b011, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 1'b0, 0, 33'h0, 33'h0};
      vecs[9]  = '{3'b010, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 1'b0, 0, 33'h0, 33'h0};
      vecs[10] = '{3'b100, 32'h12345678, 32'h00000009, 32'h00000000, 1'b1, 0, 33'h0, 33'h0};
      vecs[11] = '{3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 33'h0, 33'h0};
      vecs[12] = '{3'b001, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1, 33'h1FFFFFFFF, 33'h000000001};
      vecs[13] = '{3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 33'h0FFFFFFFF, 33'h000000001};
      vecs[14] = '{3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 0, 33'h0, 33'h0};
      vecs[15] = '{3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 1, 33'h000010000, 33'h000010000};
      vecs[16] = '{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0, 0, 33'h0, 33'h0};
      vecs[17] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1, 33'h180000000, 33'h0FFFFFFFF};
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      req_funct3 = 3'b000; req_rs1 = '0; req_rs2 = '0;
      repeat (2) @(negedge clk);
      chk("reset resp_valid", 64'(resp_valid), 64'd0);
      chk("reset resp_err", 64'(resp_err), 64'd0);
      chk("reset resp_result", 64'(resp_result), 64'd0);
      chk("reset core_start", 64'(core_start), 64'd0);
      chk("reset core_a", 64'(core_a), 64'd0);
      chk("reset core_b", 64'(core_b), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle req_ready", 64'(req_ready), 64'd1);
      s0 = start_cnt;
      req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd2; req_rs2 = 32'd2; flush = 1'b1;
      #1 chk("flush idle req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      chk("flush idle no accept", 64'(busy), 64'd0);
      req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush idle no start", 64'(start_cnt - s0), 64'd0);
      for (int i = 0; i < 18; i++) run_op(vecs[i], $sformatf("vec%0d", i));
      issue(3'b110, 32'hDEADBEEF, 32'h1, "hold");
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("hold%0d resp_valid", i), 64'(resp_valid), 64'd1);
         chk($sformatf("hold%0d result", i), 64'(resp_result), 64'd0);
         chk($sformatf("hold%0d err", i), 64'(resp_err), 64'd1);
         chk($sformatf("hold%0d req_ready", i), 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("hold released", 64'(resp_valid), 64'd0);
      issue(3'b000, 32'd5, 32'd6, "flush_wait");
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_wait drain busy", 64'(busy), 64'd1);
      chk("flush_wait resp_valid", 64'(resp_valid), 64'd0);
      wait_idle("flush_wait");
      run_op('{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 0, 33'h0, 33'h0}, "after_flush_hit");
      run_op('{3'b000, 32'd5, 32'd6, 32'd30, 1'b0, 1, 33'd5, 33'd6}, "after_flush_miss");
      issue(3'b101, 32'h1, 32'h1, "flush_resp");
      chk("flush_resp resp_valid", 64'(resp_valid), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_resp dropped", 64'(resp_valid), 64'd0);
      chk("flush_resp idle", 64'(busy), 64'd0);
      s0 = start_cnt;
      issue(3'b000, 32'd3, 32'd3, "flush_launch");
      chk("flush_launch core_start", 64'(core_start), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_launch start issued", 64'(start_cnt - s0), 64'd1);
      chk("flush_launch drain busy", 64'(busy), 64'd1);
      wait_idle("flush_launch");
      run_op('{3'b000, 32'd3, 32'd3, 32'd9, 1'b0, 1, 33'd3, 33'd3}, "after_launch_flush");
      issue(3'b000, 32'd7, 32'd7, "reset_mid");
      @(negedge clk);
      rst = 1'b1;
      #1 chk("reset_mid busy", 64'(busy), 64'd0);
      chk("reset_mid resp_valid", 64'(resp_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op('{3'b000, 32'd3, 32'd3, 32'd9, 1'b0, 1, 33'd3, 33'd3}, "after_reset_miss");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
